// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants and fetch-sequencer state encoding.
// Imported by the fetch sequencer RTL.
package cpu_isa_pkg;

   localparam int BUS_WIDTH = 16;

   localparam logic [3:0] OP_ADD              = 4'h0;
   localparam logic [3:0] OP_SUB              = 4'h1;
   localparam logic [3:0] OP_AND              = 4'h2;
   localparam logic [3:0] OP_OR               = 4'h3;
   localparam logic [3:0] OP_LOAD_TENSOR      = 4'h4;
   localparam logic [3:0] OP_TENSOR_OPERATE   = 4'h5;
   localparam logic [3:0] OP_LOAD             = 4'h6;
   localparam logic [3:0] OP_STORE            = 4'h7;
   localparam logic [3:0] OP_JUMP             = 4'h8;
   localparam logic [3:0] OP_NOP              = 4'h9;
   localparam logic [3:0] OP_READ_TENSOR_CORE = 4'hA;

   localparam logic [BUS_WIDTH-1:0] NOP_WORD = 16'h9000;
   localparam logic [BUS_WIDTH-1:0] SENTINEL = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      RUN,
      STALL,
      HALTED
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_sequencer_if.sv
// Load/control inputs and issue outputs of the fetch sequencer.
// slave = sequencer side, master = program loader / cpu side.
interface instruction_fetch_sequencer_if #(
   parameter int ADDR_WIDTH  = 10,
   parameter int INSTR_WIDTH = 16
);
   logic                   start_in;
   logic                   load_enable_in;
   logic [ADDR_WIDTH-1:0]  load_address_in;
   logic [INSTR_WIDTH-1:0] load_data_in;
   logic                   tensor_core_done_in;
   logic [INSTR_WIDTH-1:0] current_instruction;
   logic                   instruction_valid;
   logic [ADDR_WIDTH-1:0]  program_counter;
   logic [15:0]            instruction_count;
   logic                   busy;
   logic                   halted;

   modport slave (
      input  start_in, load_enable_in, load_address_in, load_data_in, tensor_core_done_in,
      output current_instruction, instruction_valid, program_counter, instruction_count,
             busy, halted
   );

   modport master (
      output start_in, load_enable_in, load_address_in, load_data_in, tensor_core_done_in,
      input  current_instruction, instruction_valid, program_counter, instruction_count,
             busy, halted
   );
endinterface

// File: rtl/program_memory.sv
// Program store: one write port, one synchronous read port (1-cycle latency).
// Read-during-write to the same address returns the old word.
module program_memory #(
   parameter int DEPTH       = 1024,
   parameter int ADDR_WIDTH  = $clog2(DEPTH),
   parameter int INSTR_WIDTH = 16
) (
   input  logic                   i_clock,
   input  logic                   i_write_en,
   input  logic [ADDR_WIDTH-1:0]  i_write_addr,
   input  logic [INSTR_WIDTH-1:0] i_write_data,
   input  logic [ADDR_WIDTH-1:0]  i_read_addr,
   output logic [INSTR_WIDTH-1:0] o_read_data
);
   logic [INSTR_WIDTH-1:0] r_mem [DEPTH];
   logic [INSTR_WIDTH-1:0] r_read_data;

   // NOTE: the array has no reset so it maps onto block RAM and survives a sequencer reset;
   // non-blocking writes are what give old-data read-during-write.
   always_ff @(posedge i_clock) begin
      if (i_write_en) begin
         r_mem[i_write_addr] <= i_write_data;
      end
      r_read_data <= r_mem[i_read_addr];
   end

   assign o_read_data = r_read_data;
endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Issues one program word per clock from address 0 until the FFFF sentinel or end of memory.
// Optional macro TENSOR_STALL_EN: hold issue after a tensor-operate word until the core is done.
module instruction_fetch_sequencer
   import cpu_isa_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int ADDR_WIDTH  = $clog2(DEPTH),
   parameter int INSTR_WIDTH = 16
) (
   input  logic clock_in,
   input  logic reset_in,
   instruction_fetch_sequencer_if.slave bus
);
   localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [INSTR_WIDTH-1:0] W_NOP     = INSTR_WIDTH'(NOP_WORD);
   localparam logic [INSTR_WIDTH-1:0] W_SENT    = INSTR_WIDTH'(SENTINEL);

   fetch_state_t           r_state, w_state_next;
   logic [ADDR_WIDTH-1:0]  r_pc, w_pc_next;
   logic [INSTR_WIDTH-1:0] r_instr, w_instr_next;
   logic                   r_valid, w_valid_next;
   logic [15:0]            r_count, w_count_next;
   logic [INSTR_WIDTH-1:0] w_rd_data;
   logic                   w_idle_like, w_write_en, w_stall_req, w_done;

   assign w_idle_like = (r_state == IDLE) || (r_state == HALTED);
   assign w_write_en  = w_idle_like && bus.load_enable_in;

`ifdef TENSOR_STALL_EN
   assign w_stall_req = (w_rd_data[INSTR_WIDTH-1 -: 4] == OP_TENSOR_OPERATE);
   assign w_done      = bus.tensor_core_done_in;
`else
   logic w_unused_done;
   assign w_unused_done = bus.tensor_core_done_in;
   assign w_stall_req   = 1'b0;
   assign w_done        = 1'b0;
`endif

   // Read address is the next PC, so rd_data already holds word[PC] whenever RUN looks at it.
   program_memory #(
      .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)
   ) u_program_memory (
      .i_clock      (clock_in),
      .i_write_en   (w_write_en),
      .i_write_addr (bus.load_address_in),
      .i_write_data (bus.load_data_in),
      .i_read_addr  (w_pc_next),
      .o_read_data  (w_rd_data)
   );

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_instr_next = W_NOP;
      w_valid_next = 1'b0;
      w_count_next = r_count;
      case (r_state)
         IDLE, HALTED: begin
            if (bus.start_in && !bus.load_enable_in) begin
               w_state_next = PRIME;
               w_pc_next    = '0;
               w_count_next = '0;
            end
         end
         PRIME: w_state_next = RUN;
         RUN: begin
            if (w_rd_data == W_SENT) begin
               w_state_next = HALTED;
            end else begin
               w_instr_next = w_rd_data;
               w_valid_next = 1'b1;
               if (r_count != 16'hFFFF) w_count_next = r_count + 16'd1;
               if (r_pc == LAST_ADDR) begin
                  w_state_next = HALTED;
               end else begin
                  w_pc_next = r_pc + 1'b1;
                  if (w_stall_req) w_state_next = STALL;
               end
            end
         end
         STALL: begin
            if (w_done) w_state_next = RUN;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         r_state <= IDLE;
         r_pc    <= '0;
         r_instr <= W_NOP;
         r_valid <= 1'b0;
         r_count <= '0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_instr <= w_instr_next;
         r_valid <= w_valid_next;
         r_count <= w_count_next;
      end
   end

   assign bus.current_instruction = r_instr;
   assign bus.instruction_valid   = r_valid;
   assign bus.program_counter     = r_pc;
   assign bus.instruction_count   = r_count;
   assign bus.busy                = (r_state == PRIME) || (r_state == RUN) || (r_state == STALL);
   assign bus.halted              = (r_state == HALTED);
endmodule
